// File: rtl/window3x3_gen_pkg.sv
// rtl/window3x3_gen_pkg.sv - shared types, window register indices and window packing
// Purpose: pixel/column/window types used by the window generator and its bus.
// Ports: none (package).
package win_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_W = 9 * PIX_W;

  typedef logic [PIX_W-1:0] pix_t;
  typedef pix_t win_t [9];

  // One vertical slice of the window, top row first.
  typedef struct packed {
    pix_t top;
    pix_t mid;
    pix_t bot;
  } col_t;

  localparam int REG_TL = 0;
  localparam int REG_TC = 1;
  localparam int REG_TR = 2;
  localparam int REG_ML = 3;
  localparam int REG_MC = 4;
  localparam int REG_MR = 5;
  localparam int REG_BL = 6;
  localparam int REG_BC = 7;
  localparam int REG_BR = 8;

  // Register n lands at bits [n*PIX_W +: PIX_W], so top-left sits in the LSBs.
  function automatic logic [WIN_W-1:0] pack(input win_t w);
    logic [WIN_W-1:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) begin
      r[i*PIX_W +: PIX_W] = w[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/window3x3_gen_if.sv
// rtl/window3x3_gen_if.sv - pixel-in / window-out handshake bus
// Purpose: groups the input pixel stream and the output window stream.
// Ports: in_valid/in_ready/in_pixel/in_sof (pixel side), out_valid/out_ready/
//        out_window/out_x/out_y (window side), frame_done (status pulse).
//        slave = window generator view, master = producer/consumer view.
interface window3x3_gen_if
  import win_pkg::*;
#(
  parameter int PW = PIX_W
);
  logic              in_valid;
  logic              in_ready;
  logic [PW-1:0]     in_pixel;
  logic              in_sof;
  logic              out_valid;
  logic              out_ready;
  logic [9*PW-1:0]   out_window;
  logic [15:0]       out_x;
  logic [15:0]       out_y;
  logic              frame_done;

  modport slave (
    input  in_valid, in_pixel, in_sof, out_ready,
    output in_ready, out_valid, out_window, out_x, out_y, frame_done
  );

  modport master (
    output in_valid, in_pixel, in_sof, out_ready,
    input  in_ready, out_valid, out_window, out_x, out_y, frame_done
  );
endinterface

// File: rtl/window3x3_gen_line_buffer.sv
// rtl/window3x3_gen_line_buffer.sv - one image line of pixel storage
// Purpose: DEPTH-entry line store, combinational read and write at the same address.
// Ports: clk, we (write enable), addr (column), wdata (new pixel), rdata (stored pixel).
module line_buffer #(
  parameter  int DEPTH = 640,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  // No reset: contents are always rewritten before they can reach a window.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/window3x3_gen.sv
// rtl/window3x3_gen.sv - streaming 3x3 pixel-window generator
// Purpose: takes raster-order pixels, keeps the two previous lines, and emits
//          one packed 3x3 window per interior pixel with its centre coordinate.
// Ports: clk, reset (sync, active-high), bus (slave side of window3x3_gen_if).
module window3x3_gen
  import win_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input logic            clk,
  input logic            reset,
  window3x3_gen_if.slave bus
);

  localparam int          AW     = $clog2(IMG_W);
  localparam logic [15:0] LAST_X = 16'(IMG_W - 1);
  localparam logic [15:0] LAST_Y = 16'(IMG_H - 1);

  logic [15:0]      x_q, y_q;
  logic [15:0]      px, py;
  logic             in_ready;
  logic             accept;
  logic             emit;
  logic             last_pix;
  pix_t             lb1_rd, lb2_rd;
  col_t             new_col;
  col_t             col_q0, col_q1;   // columns x-2 and x-1
  win_t             win_d;
  logic             out_valid_q;
  logic [WIN_W-1:0] out_window_q;
  logic [15:0]      out_x_q, out_y_q;
  logic             frame_done_q;

  // Single output register: a new pixel may enter only if the window slot
  // is empty or being drained this cycle.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // in_sof resynchronises the pixel to the frame origin.
  assign px       = bus.in_sof ? 16'd0 : x_q;
  assign py       = bus.in_sof ? 16'd0 : y_q;
  assign emit     = accept && (px >= 16'd2) && (py >= 16'd2);
  assign last_pix = (px == LAST_X) && (py == LAST_Y);

  // lb1 holds row y-1, lb2 row y-2; lb2 inherits lb1's old entry on each accept.
  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (px[AW-1:0]),
    .wdata (bus.in_pixel),
    .rdata (lb1_rd)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb2 (
    .clk   (clk),
    .we    (accept),
    .addr  (px[AW-1:0]),
    .wdata (lb1_rd),
    .rdata (lb2_rd)
  );

  assign new_col = {lb2_rd, lb1_rd, bus.in_pixel};

  // The incoming column is the right-hand column of the window directly.
  always_comb begin
    win_d         = '{default: '0};
    win_d[REG_TL] = col_q0.top;
    win_d[REG_TC] = col_q1.top;
    win_d[REG_TR] = new_col.top;
    win_d[REG_ML] = col_q0.mid;
    win_d[REG_MC] = col_q1.mid;
    win_d[REG_MR] = new_col.mid;
    win_d[REG_BL] = col_q0.bot;
    win_d[REG_BC] = col_q1.bot;
    win_d[REG_BR] = new_col.bot;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q          <= '0;
      y_q          <= '0;
      col_q0       <= '0;
      col_q1       <= '0;
      out_valid_q  <= 1'b0;
      out_window_q <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= accept && last_pix;

      if (accept) begin
        if (px == LAST_X) begin
          x_q <= '0;
          y_q <= (py == LAST_Y) ? 16'd0 : py + 16'd1;
        end else begin
          x_q <= px + 16'd1;
          y_q <= py;
        end
        // Start of a line: nothing to the left belongs to this row.
        col_q0 <= (px == 16'd0) ? '0 : col_q1;
        col_q1 <= new_col;
      end

      if (emit) begin
        out_valid_q  <= 1'b1;
        out_window_q <= pack(win_d);
        out_x_q      <= px - 16'd1;
        out_y_q      <= py - 16'd1;
      end else if (bus.out_ready) begin
        out_valid_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_window = out_window_q;
  assign bus.out_x      = out_x_q;
  assign bus.out_y      = out_y_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// tb/tb_window3x3_gen.sv - scoreboard bench for window3x3_gen
module tb_window3x3_gen;
  import win_pkg::*;

  typedef struct {
    logic [WIN_W-1:0] win;
    int               x;
    int               y;
    bit               fd;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  window3x3_gen_if i4 ();
  window3x3_gen_if i8 ();

  window3x3_gen #(.IMG_W(4), .IMG_H(4)) dut4 (.clk(clk), .reset(reset), .bus(i4.slave));
  window3x3_gen #(.IMG_W(8), .IMG_H(4)) dut8 (.clk(clk), .reset(reset), .bus(i8.slave));

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   fd4 = 0;
  int   fd8 = 0;
  int   stalls = 0;
  bit   rec = 0;
  bit   vbits[$];

  task automatic chk(input string name, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  // Expected windows for a frame of consecutive pixel values base, base+1, ...
  task automatic push_frame(input int s, input int w, input int h, input int base);
    win_t wv;
    exp_t e;
    for (int cy = 1; cy <= h - 2; cy++) begin
      for (int cx = 1; cx <= w - 2; cx++) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            wv[r*3 + c] = pix_t'(base + (cy - 1 + r) * w + (cx - 1 + c));
        e.win = pack(wv);
        e.x   = cx;
        e.y   = cy;
        e.fd  = (cy == h - 2) && (cx == w - 2);
        if (s == 0) q4.push_back(e);
        else        q8.push_back(e);
      end
    end
  endtask

  task automatic idle();
    i4.in_valid = 1'b0; i4.in_sof = 1'b0;
    i8.in_valid = 1'b0; i8.in_sof = 1'b0;
  endtask

  task automatic send(input int s, input int p, input bit sof);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    if (s == 0) begin i4.in_valid = 1'b1; i4.in_pixel = pix_t'(p); i4.in_sof = sof; end
    else        begin i8.in_valid = 1'b1; i8.in_pixel = pix_t'(p); i8.in_sof = sof; end
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = (s == 0) ? i4.in_ready : i8.in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc) stalls++;
    end
    if (!acc) chk("send timeout", 72'd0, 72'd1);
  endtask

  task automatic send_frame(input int s, input int w, input int h, input int base, input bit sof);
    for (int i = 0; i < w * h; i++) send(s, base + i, sof && (i == 0));
    idle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i4.out_ready = 1'b0;
    i8.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset dut4 out_valid", i4.out_valid, 0);
    chk("reset dut4 out_window", i4.out_window, 0);
    chk("reset dut4 out_x", i4.out_x, 0);
    chk("reset dut4 out_y", i4.out_y, 0);
    chk("reset dut4 frame_done", i4.frame_done, 0);
    chk("reset dut4 in_ready", i4.in_ready, 1);
    chk("reset dut8 out_valid", i8.out_valid, 0);
    chk("reset dut8 in_ready", i8.in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    i4.out_ready = 1'b1;
    i8.out_ready = 1'b1;
    q4.delete();
    q8.delete();
  endtask

  // Monitor: pop and compare on every accepted output window.
  always @(negedge clk) begin
    if (!reset) begin
      if (i4.frame_done) fd4++;
      if (i8.frame_done) fd8++;
      if (i4.out_valid && i4.out_ready) begin
        if (q4.size() == 0) chk("dut4 unexpected window", 72'd1, 72'd0);
        else begin
          e4 = q4.pop_front();
          chk("dut4 window", i4.out_window, e4.win);
          chk("dut4 out_x", i4.out_x, 72'(e4.x));
          chk("dut4 out_y", i4.out_y, 72'(e4.y));
          chk("dut4 frame_done", i4.frame_done, 72'(e4.fd));
        end
      end
      if (i8.out_valid && i8.out_ready) begin
        if (q8.size() == 0) chk("dut8 unexpected window", 72'd1, 72'd0);
        else begin
          e8 = q8.pop_front();
          chk("dut8 window", i8.out_window, e8.win);
          chk("dut8 out_x", i8.out_x, 72'(e8.x));
          chk("dut8 out_y", i8.out_y, 72'(e8.y));
          chk("dut8 frame_done", i8.frame_done, 72'(e8.fd));
        end
      end
      if (rec) vbits.push_back(i8.out_valid);
    end
  end

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    win_t             hw;
    logic [WIN_W-1:0] hold_win;
    logic [32:0]      got_v, exp_v;

    reset = 1'b1;
    i4.in_pixel = '0; i8.in_pixel = '0;
    idle();
    do_reset();

    // Frame 0..15, consumer always ready.
    push_frame(0, 4, 4, 0);
    send_frame(0, 4, 4, 0, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: hold the first window for 5 cycles with pixel 11 pending.
    push_frame(0, 4, 4, 20);
    for (int i = 0; i <= 10; i++) send(0, 20 + i, i == 0);
    i4.out_ready = 1'b0;
    i4.in_valid  = 1'b1;
    i4.in_pixel  = pix_t'(31);
    hw = '{20, 21, 22, 24, 25, 26, 28, 29, 30};
    hold_win = pack(hw);
    repeat (5) begin
      @(negedge clk);
      chk("bp window held", i4.out_window, hold_win);
      chk("bp out_valid held", i4.out_valid, 1);
      chk("bp in_ready low", i4.in_ready, 0);
      chk("bp out_x held", i4.out_x, 1);
    end
    @(posedge clk);
    #1;
    i4.out_ready = 1'b1;
    for (int i = 11; i <= 15; i++) send(0, 20 + i, 1'b0);
    idle();
    repeat (3) @(posedge clk);
    #1;

    // Reset part-way through a frame, then a clean frame without in_sof.
    for (int i = 0; i <= 7; i++) send(0, 40 + i, i == 0);
    idle();
    do_reset();
    push_frame(0, 4, 4, 100);
    send_frame(0, 4, 4, 100, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Six pixels of a frame, then in_sof restarts at the seventh.
    for (int i = 0; i <= 5; i++) send(0, 200 + i, i == 0);
    push_frame(0, 4, 4, 50);
    send_frame(0, 4, 4, 50, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back on the 8-wide instance: expect no stalls and valid
    // exactly one cycle after every interior accept.
    push_frame(1, 8, 4, 0);
    stalls = 0;
    rec = 1'b1;
    send_frame(1, 8, 4, 0, 1'b0);
    @(negedge clk);
    #1;
    rec = 1'b0;
    chk("b2b stalls", 72'(stalls), 0);
    chk("b2b sample count", 72'(vbits.size()), 33);
    exp_v = '0;
    got_v = '0;
    for (int i = 0; i < 32; i++) exp_v[i + 1] = ((i % 8) >= 2) && ((i / 8) >= 2);
    for (int i = 0; i < 33 && i < vbits.size(); i++) got_v[i] = vbits[i];
    chk("b2b valid pattern", 72'(got_v), 72'(exp_v));
    repeat (3) @(posedge clk);
    #1;

    chk("dut4 queue drained", 72'(q4.size()), 0);
    chk("dut8 queue drained", 72'(q8.size()), 0);
    chk("dut4 frame_done count", 72'(fd4), 4);
    chk("dut8 frame_done count", 72'(fd8), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
